hs_fifo_stage: RTL and testbench
================================

# hs_fifo_stage

Elastic req/ack buffer stage between a stream `producer` and the `din_*` input port of a generated `arf` dataflow graph. Toward upstream it behaves as a consumer: it drives `req`, and takes `ack`/data. Toward downstream it behaves as a producer: it takes `req`, and drives `ack`/data. A `depth`-entry FIFO sits between the two sides and absorbs producer stalls and graph back-pressure. The stage uses exactly the same one-cycle `ack` pulse handshake on both sides.

## Interface
- `data_width`, 32, word width.
- `depth`, 4, FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-low (`rst==0` resets).
- `din_req`  out  1  request to upstream producer (registered).
- `din_ack`  in  1  upstream ack pulse; `din` valid while high.
- `din`  in  data_width  upstream data.
- `dout_req`  in  1  request from downstream (graph `in` operator).
- `dout_ack`  out  1  one-cycle ack pulse to downstream (registered).
- `dout`  out  data_width  downstream data; valid from the `dout_ack` edge, held until the next pop.
- `occupancy`  out  $clog2(depth)+1  stored word count.
- `words_in`  out  32  push counter (see Configuration).
- `words_out`  out  32  pop counter (see Configuration).
- `overflow`  out  1  sticky error flag (see Configuration).

## Operation
- Storage: `depth` × `data_width` memory, with `wr_ptr`/`rd_ptr` of $clog2(depth) bits.
  - Pointers wrap modulo `depth`.
  - `occupancy` is tracked explicitly, so full and empty are unambiguous.
- Push: on any edge where `din_ack==1` and `occupancy<depth`:
  - `mem[wr_ptr]<=din`
  - `wr_ptr++`
- Push when full: the word is dropped and pointers are unchanged.
  - This is unreachable with a compliant producer; see the Timing proof.
- Upstream request: `din_req <= (occupancy_next < depth)`, where `occupancy_next` is the post-edge count.
- Pop: on any edge where `dout_req==1`, `dout_ack==0` and `occupancy>0`:
  - `dout<=mem[rd_ptr]`
  - `rd_ptr++`
  - `dout_ack<=1`
- Otherwise `dout_ack<=0`. `ack` is therefore never high two consecutive cycles.
- Simultaneous push and pop: both are performed and `occupancy` is unchanged.
- Pop when empty: not performed, even if a push lands on the same edge. There is no bypass path.
- `occupancy_next = occupancy + push - pop`, both terms 0/1. It never exceeds `depth`.

## Timing
- Reset (`rst==0` at an edge) clears the following to 0:
  - `din_req`, `dout_ack`, `dout`, `occupancy`, both pointers, `words_in`, `words_out`, `overflow`.
  - Memory contents are not cleared.
- Reset mid-operation: any `din_ack` sampled during reset is discarded.
- At the first edge after reset release, `din_req` rises to 1.
- Minimum latency, empty FIFO:
  - Producer asserts `din_ack` at edge t.
  - Push happens at t+1.
  - Earliest pop (`dout_ack` high, `dout` valid) at t+2.
- Throughput: one word per 2 cycles per side. This is the protocol limit, set by `ack` never being high two cycles running.
- No-overflow argument:
  - A producer ack issued at edge a is pushed at a+1.
  - The producer's next ack decision is at a+2 at the earliest.
  - That decision samples a `din_req` already reflecting the a+1 push.
  - Pops only lower `occupancy`, so all `depth` entries are usable.
- `dout` holds its last popped value while idle or empty.

## Configuration
- Macro: `HS_FIFO_STATS_EN`.
- Defined:
  - `words_in` increments on every accepted push.
  - `words_out` increments on every pop.
  - Both wrap at 2^32.
  - `overflow` is set to 1 on any `din_ack` seen while full, and stays set until reset.
- Undefined:
  - `words_in`, `words_out` and `overflow` are constant 0 and no counter logic is synthesised.
  - Data-path behaviour is identical, including dropping a word pushed while full.

## Test plan
- Reset then idle:
  - Hold `rst=0` for 3 edges → all outputs 0.
  - Release → `din_req=1` one edge later, with `occupancy=0` and `dout_ack=0`.
- Single word:
  - Producer acks `din=0x11` at t, with `dout_req` held at 1.
  - Required: `dout_ack` pulse at t+2, `dout=0x11`, and `occupancy` goes 0→1→0.
- Fill:
  - `dout_req=0`, counting producer at 0% fail rate.
  - Required: `occupancy` reaches 4, `din_req` drops at the edge of the 4th push, no further pushes occur, and `overflow=0`.
- Drain order:
  - From the full state (values 0..3), assert `dout_req`.
  - Required: pulses with `dout=0,1,2,3` on alternate cycles, then `din_req=1` again.
- Random stall soak:
  - Producer and consumer at 30% fail rate, 5000 words.
  - Required: consumer sees 0..4999 strictly in order, with `words_in==words_out==5000` (`HS_FIFO_STATS_EN` defined).
- Forced overflow:
  - With `HS_FIFO_STATS_EN`, drive `din_ack=1` with `din=0xAA` while full.
  - Required: `overflow=1` sticky, `occupancy` stays 4, and 0xAA is never emitted.

Source files
------------

// File: rtl/hs_fifo_stage_if.sv
// Handshake bundle for hs_fifo_stage: upstream req/ack/data in, downstream req/ack/data out.
// master = environment side (producer + graph), slave = the buffer stage itself.
interface hs_fifo_stage_if #(
  parameter int data_width = 32
);
  logic                  din_req;
  logic                  din_ack;
  logic [data_width-1:0] din;
  logic                  dout_req;
  logic                  dout_ack;
  logic [data_width-1:0] dout;

  modport master (
    input  din_req,
    output din_ack,
    output din,
    output dout_req,
    input  dout_ack,
    input  dout
  );

  modport slave (
    output din_req,
    input  din_ack,
    input  din,
    input  dout_req,
    output dout_ack,
    output dout
  );
endinterface

// File: rtl/hs_fifo_stage.sv
// Elastic req/ack FIFO stage between a stream producer and a dataflow graph input.
// Optional push/pop counters and sticky overflow flag under `HS_FIFO_STATS_EN.
module hs_fifo_stage #(
  parameter int data_width = 32,
  parameter int depth      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  hs_fifo_stage_if.slave           io,
  output logic [$clog2(depth):0]   occupancy,
  output logic [31:0]              words_in,
  output logic [31:0]              words_out,
  output logic                     overflow
);
  localparam int PTR_W = $clog2(depth);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(depth);

  logic [depth-1:0][data_width-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  din_req_q, din_req_d;
  logic                  dout_ack_q, dout_ack_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic                  push, pop;

  always_comb begin
    push       = io.din_ack && (occ_q < DEPTH_C);
    // No bypass: a pop needs a word already stored, and ack may not repeat back-to-back.
    pop        = io.dout_req && !dout_ack_q && (occ_q != '0);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    if (push) begin
      mem_d[wr_ptr_q] = io.din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      dout_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    occ_d      = occ_q + OCC_W'(push) - OCC_W'(pop);
    din_req_d  = (occ_d < DEPTH_C);
    dout_ack_d = pop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      din_req_q  <= 1'b0;
      dout_ack_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      din_req_q  <= din_req_d;
      dout_ack_q <= dout_ack_d;
      dout_q     <= dout_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (rst) mem_q <= mem_d;
  end

`ifdef HS_FIFO_STATS_EN
  logic [31:0] words_in_q, words_in_d, words_out_q, words_out_d;
  logic        overflow_q, overflow_d;

  always_comb begin
    words_in_d  = words_in_q + 32'(push);
    words_out_d = words_out_q + 32'(pop);
    overflow_d  = overflow_q || (io.din_ack && (occ_q == DEPTH_C));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      words_in_q  <= '0;
      words_out_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      words_in_q  <= words_in_d;
      words_out_q <= words_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign words_in  = words_in_q;
  assign words_out = words_out_q;
  assign overflow  = overflow_q;
`else
  assign words_in  = '0;
  assign words_out = '0;
  assign overflow  = 1'b0;
`endif

  assign io.din_req  = din_req_q;
  assign io.dout_ack = dout_ack_q;
  assign io.dout     = dout_q;
  assign occupancy   = occ_q;
endmodule

// File: tb/tb_hs_fifo_stage.sv
// Directed bench for hs_fifo_stage: reset, single word, fill, overflow, drain, random soak.
module tb_hs_fifo_stage;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  occupancy;
  logic [31:0] words_in, words_out;
  logic        overflow;
  int checks = 0;
  int failures = 0;

  hs_fifo_stage_if #(.data_width(DW)) bus ();

  hs_fifo_stage #(.data_width(DW), .depth(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .io        (bus.slave),
    .occupancy (occupancy),
    .words_in  (words_in),
    .words_out (words_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag, input logic [31:0] wi, input logic [31:0] wo,
                           input logic ov);
`ifdef HS_FIFO_STATS_EN
    chk({tag, "_words_in"}, words_in, wi);
    chk({tag, "_words_out"}, words_out, wo);
    chk({tag, "_overflow"}, 32'(overflow), 32'(ov));
`else
    chk({tag, "_words_in"}, words_in, 32'd0);
    chk({tag, "_words_out"}, words_out, 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
`endif
  endtask

  initial begin
    int sent, rcv, cyc;
    bus.din_ack  = 1'b0;
    bus.din      = '0;
    bus.dout_req = 1'b0;

    // Reset held for 3 edges
    rst = 1'b0;
    bus.din_ack = 1'b1;
    bus.din = 32'hDEAD;
    repeat (3) tick();
    bus.din_ack = 1'b0;
    chk("rst_din_req", 32'(bus.din_req), 0);
    chk("rst_dout_ack", 32'(bus.dout_ack), 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk_stats("rst", 0, 0, 1'b0);
    rst = 1'b1;
    tick();
    chk("rel_din_req", 32'(bus.din_req), 1);
    chk("rel_occ", 32'(occupancy), 0);
    chk("rel_dout_ack", 32'(bus.dout_ack), 0);

    // Single word, consumer always ready
    bus.dout_req = 1'b1;
    bus.din = 32'h11;
    bus.din_ack = 1'b1;
    tick();
    bus.din_ack = 1'b0;
    chk("single_occ_t1", 32'(occupancy), 1);
    chk("single_ack_t1", 32'(bus.dout_ack), 0);
    tick();
    chk("single_ack_t2", 32'(bus.dout_ack), 1);
    chk("single_dout_t2", bus.dout, 32'h11);
    chk("single_occ_t2", 32'(occupancy), 0);
    tick();
    chk("single_ack_t3", 32'(bus.dout_ack), 0);
    chk("single_dout_hold", bus.dout, 32'h11);

    // Fill with 0..3, no consumer
    bus.dout_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fill_req_before", 32'(bus.din_req), 1);
      bus.din = 32'(i);
      bus.din_ack = 1'b1;
      tick();
      bus.din_ack = 1'b0;
      chk("fill_occ", 32'(occupancy), 32'(i + 1));
      chk("fill_din_req", 32'(bus.din_req), (i == 3) ? 32'd0 : 32'd1);
      tick();
    end
    repeat (2) tick();
    chk("fill_occ_hold", 32'(occupancy), 4);
    chk_stats("fill", 5, 1, 1'b0);

    // Non-compliant push while full: dropped, flagged
    bus.din = 32'hAA;
    bus.din_ack = 1'b1;
    repeat (2) tick();
    bus.din_ack = 1'b0;
    chk("ovf_occ", 32'(occupancy), 4);
    chk_stats("ovf", 5, 1, 1'b1);
    tick();

    // Drain: 0..3 on alternate cycles, 0xAA never appears
    bus.dout_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_ack", 32'(bus.dout_ack), 1);
      chk("drain_dout", bus.dout, 32'(i));
      chk("drain_occ", 32'(occupancy), 32'(3 - i));
      tick();
      chk("drain_gap", 32'(bus.dout_ack), 0);
    end
    chk("drain_din_req", 32'(bus.din_req), 1);
    repeat (2) tick();
    chk("drain_dout_hold", bus.dout, 32'd3);
    chk_stats("drain", 5, 5, 1'b1);

    // Reset again to clear counters and the sticky flag
    bus.dout_req = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_stats("rst2", 0, 0, 1'b0);
    chk("rst2_occ", 32'(occupancy), 0);
    tick();

    // Random stall soak: 30% fail rate on both sides
    sent = 0;
    rcv = 0;
    cyc = 0;
    while (rcv < 5000 && cyc < 60000) begin
      if (bus.dout_ack) begin
        if (bus.dout !== 32'(rcv)) chk("soak_order", bus.dout, 32'(rcv));
        rcv++;
      end
      if (bus.din_ack) bus.din_ack = 1'b0;
      else if (bus.din_req && sent < 5000 && $urandom_range(0, 99) >= 30) begin
        bus.din = 32'(sent);
        bus.din_ack = 1'b1;
        sent++;
      end
      bus.dout_req = ($urandom_range(0, 99) >= 30);
      tick();
      cyc++;
    end
    bus.din_ack = 1'b0;
    bus.dout_req = 1'b0;
    chk("soak_received", 32'(rcv), 5000);
    chk("soak_sent", 32'(sent), 5000);
    chk("soak_occ", 32'(occupancy), 0);
    chk_stats("soak", 5000, 5000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
